pkt_chan_fifo: RTL and testbench

//  Per-channel elastic packet buffer between one pkt_router output channel and the

---
 rtl/spif_pkt_pkg.sv | 11 +
 rtl/pkt_chan_fifo_if.sv | 14 +
 rtl/pkt_fifo_mem.sv | 21 ++
 rtl/pkt_chan_fifo.sv | 103 ++++++++++
 tb/tb_pkt_chan_fifo.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/spif_pkt_pkg.sv
// Shared packet-path definitions for the SpiNNaker-link packet channels.
// Holds packet width, channel count and the default per-channel FIFO depth.
package spif_pkt_pkg;

  localparam int PKT_BITS        = 16;
  localparam int NUM_CHANS       = 4;
  localparam int FIFO_DEPTH_BITS = 4;

  typedef logic [PKT_BITS-1:0] pkt_t;

endpackage

// File: rtl/pkt_chan_fifo_if.sv
// Valid/ready packet stream used on both sides of a channel FIFO.
// master drives data/vld and receives rdy; slave is the mirror image.
interface pkt_chan_fifo_if
  import spif_pkt_pkg::*;
#(
  parameter int W = PKT_BITS
);
  logic [W-1:0] data;
  logic         vld;
  logic         rdy;

  modport master (output data, output vld, input rdy);
  modport slave  (input data, input vld, output rdy);
endinterface

// File: rtl/pkt_fifo_mem.sv
// Simple dual-port packet store: synchronous write, asynchronous read,
// intended to map onto distributed RAM.
module pkt_fifo_mem #(
  parameter int DATA_BITS = 16,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);
  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/pkt_chan_fifo.sv
// Per-channel elastic packet buffer (first-word fall-through) between a router
// output channel and an HSSL mux input. Optional high-water mark: PKT_CHAN_FIFO_HWM_EN.
module pkt_chan_fifo
  import spif_pkt_pkg::*;
#(
  parameter int PACKET_BITS = PKT_BITS,
  parameter int DEPTH_BITS  = FIFO_DEPTH_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_in,
  pkt_chan_fifo_if.slave        pkt_in,
  pkt_chan_fifo_if.master       pkt_out,
  output logic [DEPTH_BITS:0]   occ_out,
  input  logic                  hwm_clr_in,
  output logic [DEPTH_BITS:0]   hwm_out,
  output logic [1:0]            fifo_cnt_out
);
  localparam int PTR_W = DEPTH_BITS + 1;

  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       occ_q, occ_d;
  logic                   empty, full, in_rdy, push, pop;
  logic [PACKET_BITS-1:0] rd_data;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_BITS-1:0] == rd_ptr_q[DEPTH_BITS-1:0]) &&
                 (wr_ptr_q[DEPTH_BITS] != rd_ptr_q[DEPTH_BITS]);

  assign in_rdy       = !full && !flush_in && !reset;
  assign push         = pkt_in.vld && in_rdy;
  assign pop          = !empty && pkt_out.rdy && !reset;
  assign pkt_in.rdy   = in_rdy;
  assign pkt_out.vld  = !empty;
  assign pkt_out.data = rd_data;
  assign fifo_cnt_out = {pop, push};
  assign occ_out      = occ_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    occ_d    = occ_q;
    if (flush_in) begin
      rd_ptr_d = wr_ptr_q;
      occ_d    = '0;
    end else if (push && !pop) begin
      occ_d = occ_q + PTR_W'(1);
    end else if (pop && !push) begin
      occ_d = occ_q - PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

`ifdef PKT_CHAN_FIFO_HWM_EN
  logic [PTR_W-1:0] hwm_q, hwm_d;

  // Clear reloads the upcoming occupancy rather than zero so the mark stays meaningful.
  always_comb begin
    hwm_d = hwm_q;
    if (hwm_clr_in) begin
      hwm_d = occ_d;
    end else if (occ_d > hwm_q) begin
      hwm_d = occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) hwm_q <= '0;
    else       hwm_q <= hwm_d;
  end

  assign hwm_out = hwm_q;
`else
  logic hwm_clr_unused;
  assign hwm_clr_unused = hwm_clr_in;
  assign hwm_out        = '0;
`endif

  pkt_fifo_mem #(
    .DATA_BITS (PACKET_BITS),
    .ADDR_BITS (DEPTH_BITS)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q[DEPTH_BITS-1:0]),
    .wr_data (pkt_in.data),
    .rd_addr (rd_ptr_q[DEPTH_BITS-1:0]),
    .rd_data (rd_data)
  );
endmodule

// File: tb/tb_pkt_chan_fifo.sv
// Bench for pkt_chan_fifo: directed scenarios then random traffic, checked every
// cycle against a queue-based reference of the buffer contents.
module tb_pkt_chan_fifo;
  import spif_pkt_pkg::*;

  localparam int DEPTH = 2**FIFO_DEPTH_BITS;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic hwm_clr = 1'b0;
  logic [FIFO_DEPTH_BITS:0] occ;
  logic [FIFO_DEPTH_BITS:0] hwm;
  logic [1:0] cnt;

  pkt_chan_fifo_if in_if ();
  pkt_chan_fifo_if out_if ();

  int n_checks = 0;
  int n_fail = 0;

  pkt_t sb_q[$];
  int model_hwm = 0;

  always #5 clk = ~clk;

  pkt_chan_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .flush_in     (flush),
    .pkt_in       (in_if.slave),
    .pkt_out      (out_if.master),
    .occ_out      (occ),
    .hwm_clr_in   (hwm_clr),
    .hwm_out      (hwm),
    .fifo_cnt_out (cnt)
  );

  task automatic compare(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Evaluated mid-cycle: compare outputs with the reference, then advance it to the next edge.
  task automatic checkOutput();
    int sz;
    logic exp_rdy, exp_vld, exp_push, exp_pop;
    sz       = sb_q.size();
    exp_rdy  = (sz < DEPTH) && !flush && !reset;
    exp_vld  = (sz != 0);
    exp_push = in_if.vld && exp_rdy;
    exp_pop  = exp_vld && out_if.rdy && !reset;

    compare("in_rdy", int'(in_if.rdy), int'(exp_rdy));
    compare("out_vld", int'(out_if.vld), int'(exp_vld));
    compare("occ", int'(occ), sz);
    compare("cnt", int'(cnt), int'({exp_pop, exp_push}));
`ifdef PKT_CHAN_FIFO_HWM_EN
    compare("hwm", int'(hwm), model_hwm);
`else
    compare("hwm", int'(hwm), 0);
`endif
    if (exp_vld) compare("out_data", int'(out_if.data), int'(sb_q[0]));

    if (reset) begin
      sb_q.delete();
      model_hwm = 0;
    end else begin
      if (exp_pop) void'(sb_q.pop_front());
      if (flush) sb_q.delete();
      if (exp_push) sb_q.push_back(in_if.data);
      if (hwm_clr || sb_q.size() > model_hwm) model_hwm = sb_q.size();
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic vld, input pkt_t d,
                               input logic ordy, input logic fl, input logic clr);
    @(posedge clk);
    #1;
    reset       = rst;
    in_if.vld   = vld;
    in_if.data  = d;
    out_if.rdy  = ordy;
    flush       = fl;
    hwm_clr     = clr;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, ordy, 1'b0, 1'b0);
  endtask

  task automatic fill(input int n, input pkt_t base);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, pkt_t'(base + pkt_t'(i)), 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      checkOutput();
    end
  end

  initial begin
    in_if.vld  = 1'b0;
    in_if.data = '0;
    out_if.rdy = 1'b0;
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);

    // Fill to full, offer a 17th, then drain in order.
    fill(16, 16'h0001);
    applyStimulus(1'b0, 1'b1, 16'h0011, 1'b0, 1'b0, 1'b0);
    idle(18, 1'b1);

    // Single packet latency through an empty buffer.
    applyStimulus(1'b0, 1'b1, 16'h00AA, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);

    // Steady state at occupancy 8 with simultaneous push and pop.
    fill(8, 16'h0100);
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b1, pkt_t'(16'h0200 + i), 1'b1, 1'b0, 1'b0);
    idle(10, 1'b1);

    // Flush at occupancy 5 with a concurrent pop and an offered push.
    fill(5, 16'h0300);
    applyStimulus(1'b0, 1'b1, 16'h03FF, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0055, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b1);

    // High-water mark: fill to 12, drain to 3, clear.
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    fill(12, 16'h0400);
    idle(9, 1'b1);
    idle(2, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);
    idle(5, 1'b1);

    // Reset in the middle of traffic at occupancy 7.
    fill(7, 16'h0500);
    applyStimulus(1'b1, 1'b1, 16'h05FF, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);

    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(199) == 0),
                    ($urandom_range(9) < 7),
                    pkt_t'($urandom),
                    ($urandom_range(9) < 6),
                    ($urandom_range(29) == 0),
                    ($urandom_range(19) == 0));
    end
    idle(20, 1'b1);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
